// File: rtl/bcd_xs3_seq_conv.sv
// Handshaked multi-digit BCD <-> Excess-3 converter.
// Converts one 4-bit digit per clock, least-significant digit first, and flags illegal source codes.
module bcd_xs3_seq_conv #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic [DIGITS-1:0]   err_mask,
  output logic                out_err,
  output logic                busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    src;
  logic            src_mode;
  logic [CW+1:0]   bit_ofs;
  logic [3:0]      cur_digit;
  logic [3:0]      cur_res;
  logic            cur_err;

  // Ready only in IDLE, and never while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;

  // Convert the digit selected by the counter; illegal codes map to 4'hF.
  always_comb begin
    bit_ofs   = {cnt, 2'b00};
    cur_digit = 4'(src >> bit_ofs);
    cur_res   = 4'hF;
    cur_err   = 1'b0;
    if (!src_mode) begin
      if (cur_digit <= 4'd9) cur_res = cur_digit + 4'd3;
      else                   cur_err = 1'b1;
    end else begin
      if (cur_digit >= 4'd3 && cur_digit <= 4'd12) cur_res = cur_digit - 4'd3;
      else                                         cur_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src       <= '0;
      src_mode  <= 1'b0;
      out_data  <= '0;
      err_mask  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            src      <= in_data;
            src_mode <= mode;
            out_data <= '0;
            err_mask <= '0;
            out_err  <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          // Result starts cleared, so OR-ing each digit into place is enough.
          out_data <= out_data | (W'(cur_res) << bit_ofs);
          err_mask <= err_mask | (DIGITS'(cur_err) << cnt);
          out_err  <= out_err | cur_err;
          if (cnt == CW'(DIGITS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_xs3_seq_conv.md
Name: bcd_xs3_seq_conv

Overview:
- Parametrised, handshaked, bidirectional BCD <-> Excess-3 converter for multi-digit words.
- Converts one 4-bit digit per clock, least-significant digit first, under a small FSM.
- Flags any digit that is not a legal code in the selected source encoding.
- Sits between a valid/ready producer of packed digit words and a valid/ready consumer, replacing the single-digit combinational converters.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (>=1); data width W = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data/mode.
- in_ready  output  1  converter can accept a word (IDLE only).
- mode  input  1  0 = BCD->XS3, 1 = XS3->BCD; sampled at accept only.
- in_data  input  W  packed digits; digit i = in_data[4i+3:4i].
- out_valid  output  1  result word available.
- out_ready  input  1  consumer accepts result.
- out_data  output  W  converted digits, same packing.
- err_mask  output  DIGITS  bit i set = digit i illegal in source encoding.
- out_err  output  1  OR-reduction of err_mask.
- busy  output  1  high in CONV or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, digit counter=0.
  - out_valid=0, out_data=0, err_mask=0, out_err=0, busy=0.
  - in_ready=0 while rst is high; 1 on the first cycle after rst deasserts.
- Reset mid-operation (CONV or DONE) aborts the word; no partial result is ever presented.
- FSM states IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - Handshake = in_valid & in_ready at an edge.
  - On handshake: latch in_data and mode; clear result register and err_mask; counter=0; go to CONV.
  - in_data and mode are ignored without a handshake.
- CONV:
  - in_ready=0, busy=1.
  - Each cycle converts latched digit[counter] into result digit[counter], then counter increments.
  - After digit DIGITS-1 is converted, go to DONE. The counter never wraps past DIGITS-1.
  - Counter width = max(1, clog2(DIGITS)).
- Conversion rules, 4-bit modulo arithmetic:
  - mode 0: legal digits 0..9 -> d+3.
  - mode 1: legal digits 3..12 -> d-3.
  - Illegal digit -> result digit 4'hF and err_mask[i]=1.
- DONE:
  - out_valid=1, busy=1.
  - out_data, err_mask and out_err are stable until out_valid & out_ready at an edge.
  - On that edge: return to IDLE, out_valid=0. out_data and err_mask hold their last values.
  - out_ready is ignored outside DONE.
- Latency: if the handshake occurs in cycle C0, out_valid is high from cycle C(DIGITS+1).
- Throughput: minimum DIGITS+2 cycles per word (accept, DIGITS conversions, DONE, return to IDLE); no overlap.
- Simultaneous events:
  - in_valid during CONV/DONE is ignored; the producer must hold it.
  - rst takes priority over every handshake.
- DIGITS=1: CONV lasts exactly one cycle.

Test Plan:
- DIGITS=4, mode=0, in_data=16'h0123, out_ready=1 -> out_data=16'h3456, err_mask=4'b0000, out_err=0; out_valid rises exactly 5 cycles after the accept cycle and lasts 1 cycle.
- mode=1, in_data=16'hC963 -> out_data=16'h9630, err_mask=0. Then mode=0, in_data=16'h9A05 -> out_data=16'hCF38, err_mask=4'b0100, out_err=1.
- mode=1, in_data=16'h0F34 -> out_data=16'hFF01, err_mask=4'b1100, out_err=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and in_data -> out_valid stays 1, out_data and err_mask unchanged, in_ready=0, no second accept. Release out_ready -> IDLE next cycle with in_ready=1.
- Reset mid-word: assert rst for 1 cycle during the second CONV cycle -> next cycle out_valid=0, busy=0, in_ready=1. A new word 16'h0000, mode=0, then yields 16'h3333 with normal latency; the aborted word never appears.
- Exhaustive sweep: every 4-bit code 0..15 at every digit position, both modes, and DIGITS in {1,4,8}; compare against a reference model, including the 4'hF substitution and err_mask.
